// File: rtl/cipher_framer_pkg.sv
// Shared types and constants for the cipher framer: FSM state encoding,
// default start-of-frame marker and checksum seed.
package cipher_framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN,
    PAY,
    CSUM
  } state_e;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] CSUM_SEED        = 8'h00;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO; a push while full is accepted only when a pop
// frees the slot in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cipher_framer.sv
// Buffers encrypted bytes and emits SOF / length / payload / XOR-checksum
// frames on a valid/ready byte link; flags dropped bytes with a sticky bit.
module cipher_framer
  import cipher_framer_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FRAME_LEN = 8,
  parameter logic [7:0]  SOF_BYTE  = SOF_BYTE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             din,
  input  logic                   din_v,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   tx_sof,
  output logic                   tx_eof,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned LW       = $clog2(DEPTH) + 1;
  localparam logic [7:0]  LEN_BYTE = 8'(FRAME_LEN);
  localparam logic [7:0]  LAST_IDX = 8'(FRAME_LEN - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  fifo_head;
  logic [LW-1:0] level_w;
  logic        fifo_full, fifo_empty;
  logic        pop;

  assign pop        = (state_q == PAY) && tx_ready && !fifo_empty;
  assign overflow   = ovf_q;
  assign fifo_level = level_w;

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (din_v),
    .din  (din),
    .pop  (pop),
    .head (fifo_head),
    .level(level_w),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      csum_q  <= CSUM_SEED;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    ovf_d   = ovf_q | (din_v && fifo_full && !pop);
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        csum_d = CSUM_SEED;
        if (level_w >= LW'(FRAME_LEN)) state_d = HDR;
      end
      HDR:  if (tx_ready) state_d = LEN;
      LEN:  if (tx_ready) state_d = PAY;
      PAY: begin
        if (tx_ready) begin
          csum_d = csum_q ^ fifo_head;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == LAST_IDX) state_d = CSUM;
        end
      end
      CSUM: if (tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Head stays stable in PAY: only this state pops, and the FIFO is never
  // empty here, so concurrent pushes cannot alter the read slot.
  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    unique case (state_q)
      IDLE: ;
      HDR: begin
        tx_data  = SOF_BYTE;
        tx_valid = 1'b1;
        tx_sof   = 1'b1;
      end
      LEN: begin
        tx_data  = LEN_BYTE;
        tx_valid = 1'b1;
      end
      PAY: begin
        tx_data  = fifo_head;
        tx_valid = 1'b1;
      end
      CSUM: begin
        tx_data  = csum_q;
        tx_valid = 1'b1;
        tx_eof   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cipher_framer.sv
// Scoreboard bench for cipher_framer (DEPTH=16, FRAME_LEN=4): stimulus queues
// hand-computed frames, a negedge monitor checks every accepted beat and holds.
module tb_cipher_framer;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       din_v = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, tx_sof, tx_eof, overflow;
  logic [4:0] fifo_level;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    idle_cnt = 1000;
  int    last_gap = -1;

  always #5 clk = ~clk;

  cipher_framer #(
    .DEPTH    (16),
    .FRAME_LEN(4),
    .SOF_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_v     (din_v),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_sof    (tx_sof),
    .tx_eof    (tx_eof),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares accepted beats against the queue and checks link holds.
  initial begin
    beat_t e;
    beat_t hold_b;
    logic  hold_v;
    hold_v = 1'b0;
    hold_b = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid", 32'(tx_valid), 32'd1);
          check("hold_beat", 32'({tx_data, tx_sof, tx_eof}), 32'(hold_b));
        end
        if (!tx_valid) idle_cnt++;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got %0h expected none", {tx_data, tx_sof, tx_eof});
          end else begin
            e = exp_q.pop_front();
            check("beat", 32'({tx_data, tx_sof, tx_eof}), 32'(e));
          end
          if (tx_sof) last_gap = idle_cnt;
          if (tx_eof) idle_cnt = 0;
        end
        hold_v = tx_valid && !tx_ready;
        hold_b = {tx_data, tx_sof, tx_eof};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    din   = b;
    din_v = 1'b1;
    tick();
    din_v = 1'b0;
  endtask

  task automatic exp_frame(input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3,
                           input logic [7:0] cs);
    exp_q.push_back('{8'hA5, 1'b1, 1'b0});
    exp_q.push_back('{8'h04, 1'b0, 1'b0});
    exp_q.push_back('{p0, 1'b0, 1'b0});
    exp_q.push_back('{p1, 1'b0, 1'b0});
    exp_q.push_back('{p2, 1'b0, 1'b0});
    exp_q.push_back('{p3, 1'b0, 1'b0});
    exp_q.push_back('{cs, 1'b0, 1'b1});
  endtask

  task automatic drain(input int max, input logic bp);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      if (bp) tx_ready = (n % 3 == 0);
      tick();
      n++;
    end
    tx_ready = 1'b1;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_sof_eof", 32'({tx_sof, tx_eof}), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Basic frame
    tx_ready = 1'b1;
    exp_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    drain(50, 1'b0);

    // Back-pressure, ready pattern 1,0,0
    exp_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    drain(100, 1'b1);

    // Overflow: 17 pushes into a stalled 16-deep FIFO; 0x11 is dropped
    do_reset();
    tx_ready = 1'b0;
    exp_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    exp_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h0C);
    exp_frame(8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h04);
    exp_frame(8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h1C);
    for (int i = 1; i <= 17; i++) push(8'(i));
    check("ovf_level", 32'(fifo_level), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    tx_ready = 1'b1;
    drain(100, 1'b0);
    check("ovf_level_after", 32'(fifo_level), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    tx_ready = 1'b0;
    for (int f = 0; f < 4; f++)
      exp_frame(8'(8'h20 + 4*f), 8'(8'h21 + 4*f), 8'(8'h22 + 4*f), 8'(8'h23 + 4*f), 8'h00);
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_ovf", 32'(overflow), 32'd0);
    tx_ready = 1'b1;
    tick();
    tick();
    push(8'h30);
    check("fullpop_level", 32'(fifo_level), 32'd16);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    drain(100, 1'b0);
    check("fullpop_left", 32'(fifo_level), 32'd1);

    // Reset mid-frame
    do_reset();
    tx_ready = 1'b1;
    exp_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00);
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    tick();
    tick();
    tick();
    check("midrst_pay_head", 32'({tx_valid, tx_data}), 32'h1A1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_outputs", 32'({tx_valid, tx_sof, tx_eof, overflow, tx_data}), 32'd0);
    check("midrst_level", 32'(fifo_level), 32'd0);
    tick();
    rst = 1'b1;
    exp_frame(8'h5A, 8'h3C, 8'h0F, 8'hF0, 8'h99);
    push(8'h5A); push(8'h3C); push(8'h0F); push(8'hF0);
    drain(50, 1'b0);

    // Back-to-back frames: exactly one idle cycle between them
    exp_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    exp_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h0C);
    for (int i = 1; i <= 8; i++) push(8'(i));
    drain(100, 1'b0);
    check("b2b_gap", 32'(last_gap), 32'd1);
    check("b2b_level", 32'(fifo_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cipher_framer.md
# cipher_framer

Downstream stage of the encryption unit: captures each encrypted byte presented with its valid strobe, buffers it in a small FIFO, and emits fixed-length frames on a valid/ready byte link. Each frame is a start byte, a length byte, FRAME_LEN payload bytes and an XOR checksum byte. The block decouples the free-running encrypter output from a back-pressured transmit link and flags data loss on overflow.

## Interface
Parameters:
- DEPTH, 16, FIFO depth in bytes; power of 2, ≥ 2.
- FRAME_LEN, 8, payload bytes per frame; 1 ≤ FRAME_LEN ≤ DEPTH, ≤ 255.
- SOF_BYTE, 8'hA5, start-of-frame marker.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  8  encrypted byte from the encryption stage.
- din_v  in  1  din valid; one byte is pushed per cycle while high, with no back-pressure.
- tx_data  out  8  current frame byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte; a beat transfers when tx_valid && tx_ready.
- tx_sof  out  1  high with the SOF_BYTE beat.
- tx_eof  out  1  high with the checksum beat.
- overflow  out  1  sticky flag: set when a byte is dropped, cleared only by reset.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Reset (rst=0, asynchronous).**
  - tx_data = 0; tx_valid, tx_sof, tx_eof, overflow = 0; fifo_level = 0.
  - FIFO pointers and checksum are cleared; the FSM goes to IDLE.
  - Reset mid-frame aborts the frame. No partial frame is resumed after reset.
- **Push.**
  - When din_v=1 and the FIFO is not full, din is written.
  - When the FIFO is full and no pop happens in the same cycle, the byte is dropped and overflow is set.
  - When the FIFO is full and a pop happens in the same cycle, the push is accepted and fifo_level is unchanged.
- **Pop.** One byte is popped on each accepted PAY beat only.
- **FSM.** States are IDLE, HDR, LEN, PAY, CSUM.
  - IDLE: if fifo_level ≥ FRAME_LEN, go to HDR. The checksum is reset to 8'h00 and the payload count to 0.
  - HDR: tx_data = SOF_BYTE, tx_sof = 1. On accept, go to LEN.
  - LEN: tx_data = FRAME_LEN[7:0]. On accept, go to PAY.
  - PAY: tx_data = FIFO head. On accept: pop, checksum ^= head, count += 1. On the accept where count reaches FRAME_LEN, go to CSUM.
  - CSUM: tx_data = accumulated checksum, tx_eof = 1. On accept, go to IDLE.
- **tx_valid** is 1 in HDR, LEN, PAY and CSUM, and 0 in IDLE. tx_data = 0 in IDLE.
- **Link rules.** Once tx_valid is high, tx_data, tx_sof and tx_eof are held stable until accepted. tx_valid never drops without an accept.
- **Payload availability.** Entering HDR guarantees FRAME_LEN bytes are already buffered, so PAY never stalls on an empty FIFO.
- **Arithmetic.**
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - fifo_level is 1 bit wider than the pointers, so that full (DEPTH) and empty (0) are distinct.
  - The checksum is a bytewise XOR and has no carry.

## Timing
- Outputs depend only on registered state and the FIFO storage. There is no combinational path from tx_ready or din_v to any output.
- **Push latency.** A byte pushed at edge N is counted in fifo_level after edge N.
- **Frame start.** IDLE samples fifo_level at edge N and moves to HDR. tx_valid is high in the cycle after edge N. Minimum latency from the push that completes the payload to SOF on the link is 1 cycle.
- **Frame length.** A frame is FRAME_LEN+3 beats. With tx_ready held at 1, the beats occupy consecutive cycles.
- **Inter-frame gap.** After the CSUM accept, at least one IDLE cycle (tx_valid=0) follows before the next HDR.
- **Stall.** Holding tx_ready=0 stalls the FSM indefinitely. Pushes continue during the stall and can overflow.

## Structure
- Package cipher_framer_pkg holds:
  - the state enum typedef (IDLE, HDR, LEN, PAY, CSUM);
  - the default SOF_BYTE;
  - CSUM_SEED = 8'h00.
- Sub-module byte_fifo: synchronous single-clock FIFO, parameter DEPTH.
  - Ports: push, din, pop, head, level, full, empty. Reset is asynchronous, active-low.
  - The framer contains the FSM, payload counter and checksum register.

## Test plan
- **Basic frame.** FRAME_LEN=4, tx_ready=1; push 11,22,33,44 on consecutive cycles → link shows A5(sof),04,11,22,33,44,44(eof). The checksum is 0x44.
- **Back-pressure.** Same data, tx_ready toggled 1,0,0,1,… → identical byte sequence; each byte is held stable while tx_ready=0.
- **Overflow.** DEPTH=16, FRAME_LEN=16, tx_ready=0; push 17 bytes → fifo_level=16, overflow=1. The frame carries the first 16 bytes only.
- **Full with simultaneous pop.** FIFO full, in PAY with tx_ready=1 and din_v=1 → push accepted, fifo_level stays at DEPTH, overflow stays 0.
- **Reset mid-frame.** Assert rst during PAY → all outputs 0 immediately, fifo_level=0. After release, 4 new bytes produce a clean frame with a correct checksum.
- **Back-to-back frames.** FRAME_LEN=4, push 8 bytes continuously, tx_ready=1 → two frames separated by exactly one idle cycle; each checksum is computed over its own payload only.
